// File: rtl/memory_router_if.sv
// rtl/memory_router_if.sv - master-side request bus and broadcast slave bus for memory_router
interface memory_if;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;
    logic        memory_error;

    modport master (
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_rdata, memory_ready, memory_error
    );
    modport slave (
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_rdata, memory_ready, memory_error
    );
endinterface

interface slave_bus_if #(
    parameter int NUM_SLAVES = 3
);
    logic [NUM_SLAVES-1:0]    slave_valid;
    logic                     slave_instr;
    logic [31:0]              slave_addr;
    logic [31:0]              slave_wdata;
    logic [3:0]               slave_wstrb;
    logic [NUM_SLAVES*32-1:0] slave_rdata;
    logic [NUM_SLAVES-1:0]    slave_ready;

    modport master (
        output slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
        input  slave_rdata, slave_ready
    );
    modport slave (
        input  slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
        output slave_rdata, slave_ready
    );
endinterface

// File: rtl/memory_router.sv
// rtl/memory_router.sv - single-master, N-slave address-window router with unmapped/timeout error responses
module memory_router #(
    parameter int                     NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h0020_0000, 32'h0010_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFF0_0000},
    parameter int                     TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    memory_if.slave    mem,
    slave_bus_if.master sb
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] cnt;

    logic             hit;
    logic [SEL_W-1:0] hit_idx;
    logic             sel_ready;
    logic [31:0]      sel_rdata;
    logic             timeout_hit;
    logic             done;

    // Descending scan so the lowest-index matching window is the last to overwrite.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((mem.memory_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign sel_ready   = sb.slave_ready[sel];
    assign sel_rdata   = sb.slave_rdata[32*sel +: 32];
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign done        = (state == BUSY) && sel_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            sel            <= '0;
            cnt            <= '0;
            sb.slave_valid <= '0;
            sb.slave_instr <= 1'b0;
            sb.slave_addr  <= '0;
            sb.slave_wdata <= '0;
            sb.slave_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem.memory_valid) begin
                        sb.slave_instr <= mem.memory_instr;
                        sb.slave_addr  <= mem.memory_addr;
                        sb.slave_wdata <= mem.memory_wdata;
                        sb.slave_wstrb <= mem.memory_wstrb;
                        cnt            <= '0;
                        if (hit) begin
                            sel            <= hit_idx;
                            sb.slave_valid <= NUM_SLAVES'(1) << hit_idx;
                            state          <= BUSY;
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
                BUSY: begin
                    // Ready is checked first so a response in the last allowed cycle still completes.
                    if (sel_ready) begin
                        sb.slave_valid <= '0;
                        state          <= IDLE;
                    end else if (timeout_hit) begin
                        sb.slave_valid <= '0;
                        state          <= ERROR;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERROR: begin
                    state <= IDLE;
                end
                default: begin
                    state          <= IDLE;
                    sb.slave_valid <= '0;
                end
            endcase
        end
    end

    assign mem.memory_ready = done || (state == ERROR);
    assign mem.memory_error = (state == ERROR);
    assign mem.memory_rdata = done ? sel_rdata : 32'h0;

endmodule
